counter_sequencer: RTL and testbench

//  Sequencer for the team's WIDTH-bit modulo counter datapath. Accepts start/stop

---
 rtl/counter_sequencer_pkg.sv | 14 +
 rtl/counter_sequencer_if.sv | 31 +++
 rtl/counter_sequencer_mod_counter.sv | 44 ++++
 rtl/counter_sequencer.sv | 107 ++++++++++
 tb/tb_counter_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and default widths.
package counter_sequencer_pkg;

  localparam int unsigned DefWidth = 5;
  localparam int unsigned DefRunW  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10,
    StDone = 2'b11
  } state_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command/config and status bundle between a controller and the counter sequencer.
interface counter_sequencer_if
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned RUNW  = DefRunW
);

  logic             start;
  logic             stop;
  logic             up;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [RUNW-1:0]  runs;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, stop, up, load_val, limit, runs,
    input  count, busy, tc, done, state
  );

  modport slave (
    input  start, stop, up, load_val, limit, runs,
    output count, busy, tc, done, state
  );

endinterface

// File: rtl/counter_sequencer_mod_counter.sv
// Synchronous loadable up/down counter, modulo (limit+1).
module mod_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  logic [Width-1:0] count_q, count_d;

  // Boundary flag for the current direction; caller qualifies it with en_i.
  assign wrap_o = up_i ? (count_q == limit_i) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (ld_i) begin
      count_d = ld_val_i;
    end else if (en_i) begin
      if (up_i) begin
        count_d = wrap_o ? '0 : count_q + 1'b1;
      end else begin
        count_d = wrap_o ? limit_i : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop sequencer around mod_counter: latches config, counts wraps, signals done.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned RUNW  = DefRunW
) (
  input logic               clk,
  input logic               clear,
  counter_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic             up_q;
  logic [WIDTH-1:0] load_q, limit_q;
  logic [RUNW-1:0]  runs_q, wraps_q, wraps_d, wraps_inc;
  logic             tc_q, tc_d;
  logic             capture, ld, en, wrap;
  logic [WIDTH-1:0] ld_val, count;

  assign capture   = (state_q == StIdle) && bus.start && !bus.stop;
  assign wraps_inc = wraps_q + 1'b1;

  // Out-of-range start values snap to the first value of the chosen direction.
  assign ld_val = (load_q > limit_q) ? (up_q ? '0 : limit_q) : load_q;

  always_comb begin
    state_d = state_q;
    wraps_d = wraps_q;
    tc_d    = 1'b0;
    ld      = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StLoad;
          wraps_d = '0;
        end
      end
      StLoad: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else begin
          ld      = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else begin
          en = 1'b1;
          if (wrap) begin
            tc_d = 1'b1;
            if (wraps_q != '1) wraps_d = wraps_inc;
            if ((runs_q != '0) && (wraps_inc == runs_q)) state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= StIdle;
      wraps_q <= '0;
      tc_q    <= 1'b0;
      up_q    <= 1'b0;
      load_q  <= '0;
      limit_q <= '0;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      wraps_q <= wraps_d;
      tc_q    <= tc_d;
      if (capture) begin
        up_q    <= bus.up;
        load_q  <= bus.load_val;
        limit_q <= bus.limit;
        runs_q  <= bus.runs;
      end
    end
  end

  mod_counter #(
    .Width (WIDTH)
  ) u_mod_counter (
    .clk_i    (clk),
    .rst_ni   (clear),
    .ld_i     (ld),
    .ld_val_i (ld_val),
    .en_i     (en),
    .up_i     (up_q),
    .limit_i  (limit_q),
    .count_o  (count),
    .wrap_o   (wrap)
  );

  assign bus.count = count;
  assign bus.busy  = (state_q == StLoad) || (state_q == StRun);
  assign bus.tc    = tc_q;
  assign bus.done  = (state_q == StDone);
  assign bus.state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: cycle model feeding a scoreboard plus directed checks.
module tb_counter_sequencer;

  typedef struct packed {
    logic [1:0] st;
    logic [4:0] cnt;
    logic       busy;
    logic       tc;
    logic       done;
  } exp_t;

  logic clk;
  logic clear;
  int   n_cmp;
  int   n_err;
  int   tc_seen;
  int   done_seen;
  exp_t sb_q[$];

  // Reference model state
  logic [1:0] m_state;
  logic [4:0] m_count, m_load, m_limit;
  logic [3:0] m_runs, m_wraps;
  logic       m_up, m_tc;

  counter_sequencer_if #(.WIDTH(5), .RUNW(4)) bus ();

  counter_sequencer #(
    .WIDTH (5),
    .RUNW  (4)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic wrapped;
    if (!clear) begin
      m_state = 2'b00; m_count = '0; m_tc = 1'b0; m_wraps = '0;
      m_up = 1'b0; m_load = '0; m_limit = '0; m_runs = '0;
    end else begin
      m_tc = 1'b0;
      case (m_state)
        2'b00: if (bus.start && !bus.stop) begin
          m_up = bus.up; m_load = bus.load_val; m_limit = bus.limit; m_runs = bus.runs;
          m_wraps = '0; m_state = 2'b01;
        end
        2'b01: if (bus.stop) m_state = 2'b00;
               else begin
                 if (m_load > m_limit) m_count = m_up ? 5'd0 : m_limit;
                 else m_count = m_load;
                 m_state = 2'b10;
               end
        2'b10: if (bus.stop) m_state = 2'b00;
               else begin
                 wrapped = m_up ? (m_count == m_limit) : (m_count == 0);
                 if (m_up) m_count = wrapped ? 5'd0 : m_count + 5'd1;
                 else m_count = wrapped ? m_limit : m_count - 5'd1;
                 if (wrapped) begin
                   m_tc = 1'b1;
                   if (m_wraps != 4'hf) m_wraps = m_wraps + 4'd1;
                   if (m_runs != 0 && m_wraps == m_runs) m_state = 2'b11;
                 end
               end
        default: m_state = 2'b00;
      endcase
    end
  endtask

  task automatic tick();
    exp_t e, o;
    model_step();
    e.st = m_state; e.cnt = m_count; e.tc = m_tc;
    e.busy = (m_state == 2'b01) || (m_state == 2'b10);
    e.done = (m_state == 2'b11);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = '{st: bus.state, cnt: bus.count, busy: bus.busy, tc: bus.tc, done: bus.done};
    check_eq("sb_state", 32'(o.st), 32'(e.st));
    check_eq("sb_count", 32'(o.cnt), 32'(e.cnt));
    check_eq("sb_busy", 32'(o.busy), 32'(e.busy));
    check_eq("sb_tc", 32'(o.tc), 32'(e.tc));
    check_eq("sb_done", 32'(o.done), 32'(e.done));
    if (bus.tc) tc_seen++;
    if (bus.done) done_seen++;
  endtask

  task automatic start_seq(input logic up, input logic [4:0] lv, input logic [4:0] lim,
                           input logic [3:0] rn);
    bus.up = up; bus.load_val = lv; bus.limit = lim; bus.runs = rn; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    // Scramble inputs to show they are not re-sampled after start.
    bus.up = ~up; bus.load_val = 5'd3; bus.limit = 5'd17; bus.runs = 4'd7;
  endtask

  task automatic run_until(input logic [4:0] target, input int bound, input string tag);
    int n = 0;
    while (bus.count != target && n < bound) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(bus.count), 32'(target));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; tc_seen = 0; done_seen = 0;
    clear = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.up = 1'b0;
    bus.load_val = '0; bus.limit = '0; bus.runs = '0;
    tick(); tick();
    clear = 1'b1;
    tick();

    // Reset in the middle of a run
    start_seq(1'b1, 5'd0, 5'd9, 4'd0);
    run_until(5'd6, 20, "rst_reach6");
    check_eq("rst_pre_state", 32'(bus.state), 32'd2);
    clear = 1'b0;
    tick(); tick();
    check_eq("rst_state", 32'(bus.state), 32'd0);
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    clear = 1'b1;
    tick();

    // Up count, two wraps
    tc_seen = 0; done_seen = 0;
    start_seq(1'b1, 5'd7, 5'd9, 4'd2);
    check_eq("up_load_state", 32'(bus.state), 32'd1);
    tick();
    check_eq("up_first", 32'(bus.count), 32'd7);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) break;
    end
    check_eq("up_done", 32'(bus.done), 32'd1);
    check_eq("up_final", 32'(bus.count), 32'd0);
    check_eq("up_busy", 32'(bus.busy), 32'd0);
    check_eq("up_tcs", 32'(tc_seen), 32'd2);
    tick();
    check_eq("up_idle", 32'(bus.state), 32'd0);
    check_eq("up_dones", 32'(done_seen), 32'd1);

    // Down count, single wrap
    start_seq(1'b0, 5'd2, 5'd4, 4'd1);
    tick();
    check_eq("dn_first", 32'(bus.count), 32'd2);
    tick(); tick(); tick();
    check_eq("dn_state", 32'(bus.state), 32'd3);
    check_eq("dn_wrap", 32'(bus.count), 32'd4);
    check_eq("dn_tc", 32'(bus.tc), 32'd1);
    tick();
    check_eq("dn_idle", 32'(bus.state), 32'd0);
    check_eq("dn_hold", 32'(bus.count), 32'd4);

    // Abort at count 5
    tc_seen = 0; done_seen = 0;
    start_seq(1'b1, 5'd0, 5'd9, 4'd3);
    run_until(5'd5, 20, "ab_reach5");
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_eq("ab_state", 32'(bus.state), 32'd0);
    check_eq("ab_count", 32'(bus.count), 32'd5);
    tick();
    check_eq("ab_hold", 32'(bus.count), 32'd5);
    check_eq("ab_no_tc", 32'(tc_seen), 32'd0);
    check_eq("ab_no_done", 32'(done_seen), 32'd0);

    // Clamp out-of-range load value
    start_seq(1'b1, 5'd12, 5'd9, 4'd1);
    tick();
    check_eq("clamp_up", 32'(bus.count), 32'd0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    start_seq(1'b0, 5'd12, 5'd9, 4'd1);
    tick();
    check_eq("clamp_dn", 32'(bus.count), 32'd9);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;

    // Free run at full range with ignored start pulses
    start_seq(1'b1, 5'd0, 5'd31, 4'd0);
    tick();
    tc_seen = 0; done_seen = 0;
    for (int i = 0; i < 96; i++) begin
      bus.start = (i % 10 == 3);
      tick();
    end
    bus.start = 1'b0;
    check_eq("fr_tcs", 32'(tc_seen), 32'd3);
    check_eq("fr_no_done", 32'(done_seen), 32'd0);
    check_eq("fr_count", 32'(bus.count), 32'd0);
    check_eq("fr_state", 32'(bus.state), 32'd2);
    bus.stop = 1'b1; tick();
    bus.start = 1'b1; tick();
    check_eq("ss_idle", 32'(bus.state), 32'd0);
    bus.start = 1'b0; bus.stop = 1'b0;

    // limit 0: tc held every RUN cycle
    start_seq(1'b1, 5'd0, 5'd0, 4'd0);
    tick(); tick(); tick();
    check_eq("lim0_tc", 32'(bus.tc), 32'd1);
    check_eq("lim0_count", 32'(bus.count), 32'd0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check_eq("lim0_stop_tc", 32'(bus.tc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
